timer_nch: RTL and testbench

- Parametrised N-channel down-counting timer/PWM unit. Successor to the fixed 3-channel counter peripheral.
- Adds per-channel prescaler, one-shot / auto-reload / PWM modes, compare register, sticky terminal flags and maskable per-channel interrupts.
- Sits on the MIO bus as a word-addressed peripheral. irq[0] feeds the CPU INT line; cnt_out drives buzzer/LED/test points.

---
 rtl/timer_nch.sv | 113 +++++++++++
 tb/tb_timer_nch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_nch.sv
// timer_nch: N-channel down-counting timer/PWM unit on a word-addressed bus.
// Each channel has a prescaler and three counting modes: one-shot, auto-reload and PWM.
// Each channel also has a compare register, a sticky terminal flag and a maskable interrupt.
// Ports:
//   i_clk      system clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_we       one-cycle write strobe
//   i_addr     word address: channel = addr[AW-1:2], register = addr[1:0]
//   i_wdata    write data
//   o_rdata    combinational read data (CTRL/LOAD/CMP/COUNT)
//   o_irq      per-channel interrupt = FLAG & IE
//   o_cnt_out  per-channel registered waveform output
module timer_nch #(
    parameter int CH      = 4,
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 16,
    parameter int AW      = $clog2(CH) + 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata,
    output logic [CH-1:0] o_irq,
    output logic [CH-1:0] o_cnt_out
);
    logic [AW-1:0] w_ch;
    logic [31:0]   w_rd [CH][4];

    assign w_ch = i_addr >> 2;

    // Addresses that decode to a channel >= CH match no entry and read 0.
    always_comb begin
        o_rdata = '0;
        for (int k = 0; k < CH; k++)
            if (w_ch == AW'(k)) o_rdata = w_rd[k][i_addr[1:0]];
    end

    genvar c;
    for (c = 0; c < CH; c++) begin : g_ch
        logic               r_en, r_ie, r_flag, r_out;
        logic [1:0]         r_mode;
        logic [PRESC_W-1:0] r_presc, r_pcnt;
        logic [WIDTH-1:0]   r_load, r_cmp, r_count;
        logic               w_sel, w_ctrl_wr, w_load_wr, w_cmp_wr;
        logic               w_tick, w_zero, w_term, w_out_nx;
        logic [WIDTH-1:0]   w_wd, w_next;
        logic [PRESC_W-1:0] w_pcnt_nx;

        assign w_sel     = i_we && (w_ch == AW'(c));
        assign w_ctrl_wr = w_sel && (i_addr[1:0] == 2'd0);
        assign w_load_wr = w_sel && (i_addr[1:0] == 2'd1);
        assign w_cmp_wr  = w_sel && (i_addr[1:0] == 2'd2);
        assign w_wd      = i_wdata[WIDTH-1:0];

        // A LOAD write on the same edge swallows the tick entirely.
        // Hold mode never ticks.
        assign w_tick = r_en && (r_mode != 2'd3) && (r_pcnt == r_presc) && !w_load_wr;
        assign w_zero = (r_count == '0);
        assign w_next = w_zero ? ((r_mode == 2'd0) ? '0 : r_load) : r_count - 1'b1;
        // One-shot terminates on 1->0 or when ticked at 0; reload modes terminate at 0.
        assign w_term = w_tick && ((r_mode == 2'd0) ? (w_zero || r_count == WIDTH'(1)) : w_zero);
        assign w_out_nx = (r_mode == 2'd2) ? (w_next < r_cmp) :
                          w_term ? ((r_mode == 2'd0) ? 1'b1 : ~r_out) : r_out;
        assign w_pcnt_nx = (w_ctrl_wr || w_load_wr || !r_en) ? '0 :
                           (r_mode == 2'd3) ? r_pcnt :
                           (r_pcnt == r_presc) ? '0 : r_pcnt + 1'b1;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_en    <= 1'b0;
                r_ie    <= 1'b0;
                r_flag  <= 1'b0;
                r_out   <= 1'b0;
                r_mode  <= '0;
                r_presc <= '0;
                r_pcnt  <= '0;
                r_load  <= '0;
                r_cmp   <= '0;
                r_count <= '0;
            end else begin
                if (w_ctrl_wr) begin
                    r_en    <= i_wdata[0];
                    r_mode  <= i_wdata[2:1];
                    r_ie    <= i_wdata[3];
                    r_presc <= i_wdata[8 +: PRESC_W];
                end
                if (w_term && r_mode == 2'd0) r_en <= 1'b0;
                if (w_load_wr) r_load <= w_wd;
                if (w_cmp_wr) r_cmp <= w_wd;
                // Terminal-count set beats a same-edge clear.
                if (w_term) r_flag <= 1'b1;
                else if (w_ctrl_wr && i_wdata[31]) r_flag <= 1'b0;
                r_pcnt <= w_pcnt_nx;
                if (w_load_wr) begin
                    r_count <= w_wd;
                    r_out   <= (r_mode == 2'd2) && (w_wd < r_cmp);
                end else if (w_tick) begin
                    r_count <= w_next;
                    r_out   <= w_out_nx;
                end
            end
        end

        assign w_rd[c][0] = (32'(r_presc) << 8) | {r_flag, 27'd0, r_ie, r_mode, r_en};
        assign w_rd[c][1] = 32'(r_load);
        assign w_rd[c][2] = 32'(r_cmp);
        assign w_rd[c][3] = 32'(r_count);
        assign o_irq[c]     = r_flag & r_ie;
        assign o_cnt_out[c] = r_out;
    end
endmodule

// File: tb/tb_timer_nch.sv
// tb_timer_nch: directed self-checking bench for timer_nch (3 channels, so channel 3 is unmapped).
module tb_timer_nch;
    localparam int CH = 3;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic [CH-1:0] irq, cnt_out;
    int            n_chk = 0;
    int            n_fail = 0;
    int            n_hi;
    logic [31:0]   exp_v;

    always #5 clk = ~clk;

    timer_nch #(.CH(CH), .WIDTH(32), .PRESC_W(16)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_we(we),
        .i_addr(addr),
        .i_wdata(wdata),
        .o_rdata(rdata),
        .o_irq(irq),
        .o_cnt_out(cnt_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, expv);
        end
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [31:0] expv);
        addr = a;
        #1;
        chk(tag, rdata, expv);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1;
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_out", 32'(cnt_out), 32'd0);
        for (int a = 0; a < 12; a++) rd("rst_reg", AW'(a), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(3);
        rd("post_rst_cnt", 4'd3, 32'd0);

        // one-shot on ch0
        wr(4'd1, 32'd5);
        rd("os_load_cnt", 4'd3, 32'd5);
        wr(4'd0, 32'h9);
        rd("os_start", 4'd3, 32'd5);
        for (int v = 4; v >= 0; v--) begin
            step(1);
            rd("os_cnt", 4'd3, 32'(v));
        end
        rd("os_ctrl", 4'd0, 32'h8000_0008);
        chk("os_irq", 32'(irq), 32'd1);
        chk("os_out", 32'(cnt_out), 32'd1);
        step(2);
        rd("os_hold", 4'd3, 32'd0);
        wr(4'd0, 32'h0);
        chk("ie_mask_irq", 32'(irq), 32'd0);
        rd("ie_mask_flag", 4'd0, 32'h8000_0000);
        wr(4'd0, 32'h8000_0000);
        rd("flag_clr", 4'd0, 32'd0);
        chk("flag_clr_irq", 32'(irq), 32'd0);

        // auto-reload with prescaler 2 on ch1
        wr(4'd5, 32'd3);
        wr(4'd4, 32'h203);
        rd("ar_c0", 4'd7, 32'd3);
        step(2);
        rd("ar_pre", 4'd7, 32'd3);
        step(1);
        rd("ar_t1", 4'd7, 32'd2);
        step(3);
        rd("ar_t2", 4'd7, 32'd1);
        step(3);
        rd("ar_t3", 4'd7, 32'd0);
        chk("ar_out_lo", 32'(cnt_out[1]), 32'd0);
        rd("ar_noflag", 4'd4, 32'h203);
        step(3);
        rd("ar_reload", 4'd7, 32'd3);
        chk("ar_out_hi", 32'(cnt_out[1]), 32'd1);
        rd("ar_flag", 4'd4, 32'h8000_0203);
        step(11);
        rd("ar_pre2", 4'd7, 32'd0);
        chk("ar_out_hold", 32'(cnt_out[1]), 32'd1);
        step(1);
        rd("ar_reload2", 4'd7, 32'd3);
        chk("ar_out_toggle", 32'(cnt_out[1]), 32'd0);
        wr(4'd4, 32'h8000_0203);
        rd("ar_clr", 4'd4, 32'h203);
        step(11);
        rd("col_pre", 4'd7, 32'd0);
        wr(4'd4, 32'h8000_0203);
        rd("col_flag", 4'd4, 32'h8000_0203);
        rd("col_cnt", 4'd7, 32'd3);
        wr(4'd4, 32'h8000_0000);
        rd("ch1_off", 4'd4, 32'd0);
        rd("ch1_hold", 4'd7, 32'd3);

        // LOAD write colliding with a tick on ch0
        wr(4'd0, 32'h3);
        wr(4'd1, 32'd100);
        rd("ld_col_cnt", 4'd3, 32'd100);
        rd("ld_col_noflag", 4'd0, 32'h3);
        step(1);
        rd("ld_next", 4'd3, 32'd99);
        wr(4'd0, 32'h0);
        rd("dis_cnt", 4'd3, 32'd98);
        wr(4'd3, 32'd77);
        rd("cnt_ro", 4'd3, 32'd98);
        rd("load_keep", 4'd1, 32'd100);

        // PWM on ch2
        wr(4'd10, 32'd3);
        wr(4'd9, 32'd9);
        wr(4'd8, 32'h5);
        rd("pwm_c0", 4'd11, 32'd9);
        n_hi = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            exp_v = 32'(((9 - k) % 10 + 10) % 10);
            rd("pwm_cnt", 4'd11, exp_v);
            chk("pwm_out", 32'(cnt_out[2]), 32'(exp_v < 32'd3));
            n_hi += int'(cnt_out[2]);
        end
        chk("pwm_duty", 32'(n_hi), 32'd6);
        wr(4'd10, 32'd0);
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("pwm_cmp0", 32'(cnt_out[2]), 32'd0);
        end
        wr(4'd10, 32'd10);
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("pwm_cmp_big", 32'(cnt_out[2]), 32'd1);
        end
        wr(4'd8, 32'h0);

        // all channels auto-reload with distinct periods
        wr(4'd1, 32'd1);
        wr(4'd5, 32'd2);
        wr(4'd9, 32'd3);
        wr(4'd0, 32'h3);
        wr(4'd4, 32'h3);
        wr(4'd8, 32'h3);
        for (int n = 0; n < 24; n++) begin
            exp_v = {29'd0, 1'((n / 4) % 2), 1'(((n + 1) / 3) % 2), 1'(((n + 2) / 2) % 2)};
            chk("indep_out", 32'(cnt_out), exp_v);
            step(1);
        end

        // unmapped channel 3
        wr(4'd13, 32'hAA);
        rd("bad_rd_load", 4'd13, 32'd0);
        rd("bad_rd_ctrl", 4'd12, 32'd0);
        rd("keep_ld0", 4'd1, 32'd1);
        rd("keep_ld1", 4'd5, 32'd2);
        rd("keep_ld2", 4'd9, 32'd3);

        // asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        chk("mrst_irq", 32'(irq), 32'd0);
        chk("mrst_out", 32'(cnt_out), 32'd0);
        for (int a = 0; a < 12; a++) rd("mrst_reg", AW'(a), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(5);
        rd("mrst_cnt0", 4'd3, 32'd0);
        rd("mrst_cnt1", 4'd7, 32'd0);
        rd("mrst_ctrl2", 4'd8, 32'd0);
        chk("mrst_out_after", 32'(cnt_out), 32'd0);
        wr(4'd1, 32'd7);
        step(3);
        rd("mrst_no_tick", 4'd3, 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
